// File: rtl/oled_cmd_seq_if.sv
// Handshake bundle between the display controller, the command sequencer and the I2C byte-writer.
// The master modport is the controller/writer side; the slave modport is the sequencer.
interface oled_cmd_seq_if;
  logic        start;
  logic        mode;
  logic [7:0]  fill_byte;
  logic        abort;
  logic        write_done;
  logic        frame_valid;
  logic [23:0] frame_data;
  logic        busy;
  logic        done;

  modport master (
    output start, mode, fill_byte, abort, write_done,
    input  frame_valid, frame_data, busy, done
  );

  modport slave (
    input  start, mode, fill_byte, abort, write_done,
    output frame_valid, frame_data, busy, done
  );
endinterface

// File: rtl/oled_cmd_seq.sv
// SSD1306 I2C frame sequencer: 27-command init or page-addressed constant fill.
// Define OLED_FLIP_EN to rotate the panel 180 degrees (init entries 7/11 become A0/C0).
module oled_cmd_seq #(
  parameter logic [7:0]  DEV_ADDR = 8'h78,
  parameter logic [7:0]  CONTRAST = 8'hFF,
  parameter int unsigned PAGES    = 8,
  parameter int unsigned COLS     = 128
) (
  input logic             i_sys_clk,
  input logic             i_rst,
  oled_cmd_seq_if.slave   io_bus
);

  localparam int unsigned   CW        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [4:0]    INIT_LAST = 5'd26;
  localparam logic [2:0]    PAGE_LAST = 3'(PAGES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [7:0]    CTRL_CMD  = 8'h00;
  localparam logic [7:0]    CTRL_DATA = 8'h40;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StFillCmd,
    StFillData,
    StFinish
  } state_e;

  state_e        r_state, w_state_d;
  logic [4:0]    r_idx, w_idx_d;
  logic [2:0]    r_page, w_page_d;
  logic [1:0]    r_sub, w_sub_d;
  logic [CW-1:0] r_col, w_col_d;
  logic [7:0]    r_fill, w_fill_d;
  logic          r_valid, w_valid_d;
  logic [23:0]   r_data, w_data_d;
  logic          r_busy, w_busy_d;
  logic          r_done, w_done_d;
  logic          w_ack;

  function automatic logic [7:0] init_payload(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'h00;
      5'd2:    b = 8'h10;
      5'd3:    b = 8'h40;
      5'd4:    b = 8'hB0;
      5'd5:    b = 8'h81;
      5'd6:    b = CONTRAST;
`ifdef OLED_FLIP_EN
      5'd7:    b = 8'hA0;
`else
      5'd7:    b = 8'hA1;
`endif
      5'd8:    b = 8'hA6;
      5'd9:    b = 8'hA8;
      5'd10:   b = 8'h3F;
`ifdef OLED_FLIP_EN
      5'd11:   b = 8'hC0;
`else
      5'd11:   b = 8'hC8;
`endif
      5'd12:   b = 8'hD3;
      5'd13:   b = 8'h00;
      5'd14:   b = 8'hD5;
      5'd15:   b = 8'h80;
      5'd16:   b = 8'hD8;
      5'd17:   b = 8'h05;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDA;
      5'd21:   b = 8'h12;
      5'd22:   b = 8'hDB;
      5'd23:   b = 8'h30;
      5'd24:   b = 8'h8D;
      5'd25:   b = 8'h14;
      5'd26:   b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Page header: set page, then column low/high nibble to 0.
  function automatic logic [7:0] page_cmd(input logic [2:0] page, input logic [1:0] sub);
    logic [7:0] b;
    case (sub)
      2'd0:    b = 8'hB0 + {5'b0, page};
      2'd1:    b = 8'h00;
      default: b = 8'h10;
    endcase
    return b;
  endfunction

  assign w_ack = r_valid & io_bus.write_done;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_page_d  = r_page;
    w_sub_d   = r_sub;
    w_col_d   = r_col;
    w_fill_d  = r_fill;
    w_valid_d = r_valid;
    w_data_d  = r_data;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;

    case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_fill_d  = io_bus.fill_byte;
          w_busy_d  = 1'b1;
          w_valid_d = 1'b1;
          w_idx_d   = '0;
          w_page_d  = '0;
          w_sub_d   = '0;
          w_col_d   = '0;
          if (io_bus.mode) begin
            w_state_d = StFillCmd;
            w_data_d  = {DEV_ADDR, CTRL_CMD, page_cmd(3'd0, 2'd0)};
          end else begin
            w_state_d = StInit;
            w_data_d  = {DEV_ADDR, CTRL_CMD, init_payload(5'd0)};
          end
        end
      end

      StInit: begin
        if (w_ack) begin
          if (r_idx == INIT_LAST) begin
            w_state_d = StFinish;
            w_valid_d = 1'b0;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
          end else begin
            w_idx_d  = r_idx + 5'd1;
            w_data_d = {DEV_ADDR, CTRL_CMD, init_payload(r_idx + 5'd1)};
          end
        end
      end

      StFillCmd: begin
        if (w_ack) begin
          if (r_sub == 2'd2) begin
            w_state_d = StFillData;
            w_col_d   = '0;
            w_data_d  = {DEV_ADDR, CTRL_DATA, r_fill};
          end else begin
            w_sub_d  = r_sub + 2'd1;
            w_data_d = {DEV_ADDR, CTRL_CMD, page_cmd(r_page, r_sub + 2'd1)};
          end
        end
      end

      StFillData: begin
        if (w_ack) begin
          if (r_col != COL_LAST) begin
            w_col_d = r_col + CW'(1);
          end else if (r_page != PAGE_LAST) begin
            w_state_d = StFillCmd;
            w_page_d  = r_page + 3'd1;
            w_sub_d   = '0;
            w_data_d  = {DEV_ADDR, CTRL_CMD, page_cmd(r_page + 3'd1, 2'd0)};
          end else begin
            w_state_d = StFinish;
            w_valid_d = 1'b0;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
          end
        end
      end

      StFinish: w_state_d = StIdle;

      default: w_state_d = StIdle;
    endcase

    // Abort wins over a same-cycle write_done; busy is low in IDLE/FINISH so it is a no-op there.
    if (io_bus.abort && r_busy) begin
      w_state_d = StIdle;
      w_valid_d = 1'b0;
      w_busy_d  = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_page  <= '0;
      r_sub   <= '0;
      r_col   <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_page  <= w_page_d;
      r_sub   <= w_sub_d;
      r_col   <= w_col_d;
      r_fill  <= w_fill_d;
      r_valid <= w_valid_d;
      r_data  <= w_data_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign io_bus.frame_valid = r_valid;
  assign io_bus.frame_data  = r_data;
  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;

endmodule

// File: tb/tb_oled_cmd_seq.sv
// Scoreboard bench for oled_cmd_seq: a randomized writer acks frames, a monitor pops expected frames.
`timescale 1ns/1ps
module tb_oled_cmd_seq;

  localparam logic [7:0] DevAddr  = 8'h78;
  localparam logic [7:0] Contrast = 8'hFF;
  localparam int         Pages    = 2;
  localparam int         Cols     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oled_cmd_seq_if bus ();

  oled_cmd_seq #(
    .DEV_ADDR (DevAddr),
    .CONTRAST (Contrast),
    .PAGES    (Pages),
    .COLS     (Cols)
  ) dut (
    .i_sys_clk (clk),
    .i_rst     (rst),
    .io_bus    (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] exp_q[$];
  int          n_acc    = 0;
  int          n_done   = 0;
  int          n_done_exp = 0;
  int          n_issued = 0;
  int          ack_limit = 0;
  logic        wd_auto  = 1'b0;
  logic        wd_force = 1'b0;

  assign bus.write_done = wd_auto | wd_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference command table, straight from the panel datasheet ordering.
  function automatic logic [7:0] init_ref(input int i);
    logic [7:0] tab [27];
    tab = '{8'hAE, 8'h00, 8'h10, 8'h40, 8'hB0, 8'h81, Contrast, 8'hA1, 8'hA6, 8'hA8, 8'h3F,
            8'hC8, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD8, 8'h05, 8'hD9, 8'hF1, 8'hDA, 8'h12,
            8'hDB, 8'h30, 8'h8D, 8'h14, 8'hAF};
`ifdef OLED_FLIP_EN
    tab[7]  = 8'hA0;
    tab[11] = 8'hC0;
`endif
    return tab[i];
  endfunction

  function automatic void push_seq(input logic m, input logic [7:0] f);
    if (!m) begin
      for (int i = 0; i < 27; i++) exp_q.push_back({DevAddr, 8'h00, init_ref(i)});
    end else begin
      for (int p = 0; p < Pages; p++) begin
        exp_q.push_back({DevAddr, 8'h00, 8'hB0 + 8'(p)});
        exp_q.push_back({DevAddr, 8'h00, 8'h00});
        exp_q.push_back({DevAddr, 8'h00, 8'h10});
        for (int c = 0; c < Cols; c++) exp_q.push_back({DevAddr, 8'h40, f});
      end
    end
  endfunction

  // I2C writer model: random gap before each ack, capped by ack_limit.
  initial begin
    int gap;
    gap = 2;
    forever begin
      @(posedge clk);
      #2;
      if (wd_auto) begin
        wd_auto = 1'b0;
        gap = $urandom_range(0, 3);
      end else if (bus.frame_valid && n_issued < ack_limit) begin
        if (gap == 0) begin
          wd_auto = 1'b1;
          n_issued++;
        end else begin
          gap--;
        end
      end
    end
  end

  // Monitor: pops on each accepted frame, checks hold stability and done.
  initial begin
    logic [23:0] prev_data;
    logic        prev_hold;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && bus.frame_valid) check("data_stable", bus.frame_data, prev_data);
        if (bus.frame_valid && bus.write_done && !bus.abort) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: got %h, expected no frame", bus.frame_data);
          end else begin
            check("frame", bus.frame_data, exp_q.pop_front());
          end
          n_acc++;
        end
        if (bus.done) begin
          n_done++;
          check("done_queue_empty", exp_q.size(), 0);
          check("done_busy_low", bus.busy, 1'b0);
        end
        prev_hold = bus.frame_valid && !bus.write_done;
        prev_data = bus.frame_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic m, input logic [7:0] f, input int limit);
    push_seq(m, f);
    n_issued  = 0;
    ack_limit = limit;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.fill_byte = f;
    tick();
    bus.start = 1'b0;
    check("start_valid", bus.frame_valid, 1'b1);
    check("start_busy", bus.busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int base;
    int k;
    base = n_done;
    k = 0;
    while (n_done == base && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", 32'(n_done != base), 1);
    n_done_exp++;
    repeat (3) tick();
    check("done_count", n_done, n_done_exp);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_valid", bus.frame_valid, 1'b0);
  endtask

  task automatic wait_issued(input int target, input int budget);
    int k;
    k = 0;
    while (!(n_issued == target && !wd_auto) && k < budget) begin
      tick();
      k++;
    end
    check("acks_reached", n_issued, target);
  endtask

  initial begin
    logic [23:0] held;
    logic [7:0]  f;
    int          base;
    int          k;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.fill_byte = 8'h00;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.frame_valid, 1'b0);
    check("rst_data", bus.frame_data, 24'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst = 1'b0;
    tick();

    // Abort while idle does nothing.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle_abort_busy", bus.busy, 1'b0);

    // Full init, then the directed fill with a zero byte.
    start_seq(1'b0, 8'h00, 1000);
    check("init_first", bus.frame_data, 24'h7800AE);
    wait_done(400);
    start_seq(1'b1, 8'h00, 1000);
    check("fill_first", bus.frame_data, 24'h7800B0);
    wait_done(400);

    // Writer stalls on init frame 5; starts and input changes during busy are ignored.
    start_seq(1'b0, 8'h5A, 5);
    wait_issued(5, 100);
    held = bus.frame_data;
    check("stall_frame", held, {DevAddr, 8'h00, 8'h81});
    for (int i = 0; i < 50; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.mode = 1'($urandom_range(0, 1));
      bus.fill_byte = 8'($urandom);
      tick();
    end
    bus.start = 1'b0;
    check("stall_hold_data", bus.frame_data, held);
    check("stall_hold_valid", bus.frame_valid, 1'b1);
    ack_limit = 1000;
    wait_done(400);

    // Abort coincident with write_done on init frame 10.
    start_seq(1'b0, 8'h00, 10);
    wait_issued(10, 200);
    check("abort_frame", bus.frame_data, {DevAddr, 8'h00, 8'h3F});
    wd_force = 1'b1;
    bus.abort = 1'b1;
    tick();
    wd_force = 1'b0;
    bus.abort = 1'b0;
    check("abort_valid", bus.frame_valid, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    exp_q.delete();
    repeat (5) tick();
    check("abort_no_done", n_done, n_done_exp);
    start_seq(1'b0, 8'h00, 1000);
    check("restart_first", bus.frame_data, 24'h7800AE);
    wait_done(400);

    // Asynchronous reset during FILL_DATA.
    f = 8'($urandom);
    base = n_acc;
    start_seq(1'b1, f, 1000);
    k = 0;
    while (n_acc - base < 5 && k < 200) begin
      tick();
      k++;
    end
    check("fill_data_reached", bus.frame_data, {DevAddr, 8'h40, f});
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", bus.frame_valid, 1'b0);
    check("arst_data", bus.frame_data, 24'h0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    ack_limit = 0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      wd_force = 1'b1;
      tick();
      wd_force = 1'b0;
      tick();
      check("idle_wd_valid", bus.frame_valid, 1'b0);
    end
    check("arst_no_done", n_done, n_done_exp);

    // Random sequences.
    for (int r = 0; r < 6; r++) begin
      start_seq(1'($urandom_range(0, 1)), 8'($urandom), 1000);
      wait_done(400);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
